button_pulse_gen: RTL and testbench

//  Parametrised front end for N asynchronous push-buttons/switches.
//  - Synchronises and debounces each channel; exposes the debounced level.
//  - Emits a one-cycle press pulse per press and a one-cycle release pulse per release.
//  - Feeds edit/transport controls of the composer FSMs; channels fully independent.

---
 rtl/button_pulse_gen.sv | 121 ++++++++++++
 tb/tb_button_pulse_gen.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/button_pulse_gen.sv
// Synchronise, debounce and edge-detect N independent push-button inputs into a level and press/release pulses.
// Define BUTTON_AUTOREPEAT_EN to add periodic repeat pulses on button_pulse while a button stays held.
module button_pulse_gen #(
    parameter int N_CH          = 4,
    parameter int DEBOUNCE_LEN  = 4,
    parameter int REPEAT_DELAY  = 16,
    parameter int REPEAT_PERIOD = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] buttons,
    output logic [N_CH-1:0] button_level,
    output logic [N_CH-1:0] button_pulse,
    output logic [N_CH-1:0] release_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LEN - 1);

    logic [N_CH-1:0]  s1_q, s1_d;
    logic [N_CH-1:0]  s2_q, s2_d;
    logic [N_CH-1:0]  db_q, db_d;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [N_CH-1:0]  press_pulse_q, press_pulse_d;
    logic [N_CH-1:0]  release_pulse_q, release_pulse_d;
    logic [N_CH-1:0]  repeat_fire;

    always_comb begin
        s1_d = buttons;
        s2_d = s1_q;
        db_d = db_q;
        for (int ch = 0; ch < N_CH; ch++) begin
            cnt_d[ch] = '0;
            if (s2_q[ch] != db_q[ch]) begin
                if (cnt_q[ch] == CNT_LAST) begin
                    db_d[ch] = s2_q[ch];
                end else begin
                    cnt_d[ch] = cnt_q[ch] + 1'b1;
                end
            end
        end
        press_pulse_d   = (db_d & ~db_q) | repeat_fire;
        release_pulse_d = ~db_d & db_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q            <= '0;
            s2_q            <= '0;
            db_q            <= '0;
            press_pulse_q   <= '0;
            release_pulse_q <= '0;
            for (int ch = 0; ch < N_CH; ch++) begin
                cnt_q[ch] <= '0;
            end
        end else begin
            s1_q            <= s1_d;
            s2_q            <= s2_d;
            db_q            <= db_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            for (int ch = 0; ch < N_CH; ch++) begin
                cnt_q[ch] <= cnt_d[ch];
            end
        end
    end

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RC_W    = $clog2(RPT_MAX + 1);
    localparam logic [RC_W-1:0] DELAY_LAST  = RC_W'(REPEAT_DELAY - 1);
    localparam logic [RC_W-1:0] PERIOD_LAST = RC_W'(REPEAT_PERIOD - 1);

    logic [RC_W-1:0] rc_q [N_CH];
    logic [RC_W-1:0] rc_d [N_CH];
    // rpt marks that the initial delay has elapsed and the counter now times the period
    logic [N_CH-1:0] rpt_q, rpt_d;

    always_comb begin
        repeat_fire = '0;
        rpt_d       = rpt_q;
        for (int ch = 0; ch < N_CH; ch++) begin
            rc_d[ch] = rc_q[ch];
            if (!db_d[ch] || !db_q[ch]) begin
                rc_d[ch]  = '0;
                rpt_d[ch] = 1'b0;
            end else if (rc_q[ch] == (rpt_q[ch] ? PERIOD_LAST : DELAY_LAST)) begin
                repeat_fire[ch] = 1'b1;
                rc_d[ch]        = '0;
                rpt_d[ch]       = 1'b1;
            end else begin
                rc_d[ch] = rc_q[ch] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rpt_q <= '0;
            for (int ch = 0; ch < N_CH; ch++) begin
                rc_q[ch] <= '0;
            end
        end else begin
            rpt_q <= rpt_d;
            for (int ch = 0; ch < N_CH; ch++) begin
                rc_q[ch] <= rc_d[ch];
            end
        end
    end
`else
    always_comb begin
        repeat_fire = '0;
    end
`endif

    assign button_level  = db_q;
    assign button_pulse  = press_pulse_q;
    assign release_pulse = release_pulse_q;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Randomised scoreboard bench: a default 4-channel instance plus a 1-channel DEBOUNCE_LEN=1 instance.
module tb_button_pulse_gen;

    localparam int N_CH   = 4;
    localparam int DB_LEN = 4;
    localparam int RD     = 16;
    localparam int RP     = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N_CH-1:0] buttons;
    logic [N_CH-1:0] button_level, button_pulse, release_pulse;
    logic [0:0]      small_btn;
    logic [0:0]      small_level, small_pulse, small_release;

    button_pulse_gen #(.N_CH(N_CH), .DEBOUNCE_LEN(DB_LEN), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .clk(clk), .reset(reset), .buttons(buttons),
        .button_level(button_level), .button_pulse(button_pulse), .release_pulse(release_pulse)
    );

    button_pulse_gen #(.N_CH(1), .DEBOUNCE_LEN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_small (
        .clk(clk), .reset(reset), .buttons(small_btn),
        .button_level(small_level), .button_pulse(small_pulse), .release_pulse(small_release)
    );

    always #5 clk = ~clk;

    // channels 0..3 belong to the default instance, channel 4 to the small one
    typedef struct packed {
        logic [4:0] lvl;
        logic [4:0] bp;
        logic [4:0] rp;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    // Reference: a channel adopts a new value once its synchronised input (two edges late)
    // has disagreed with the current level for the last LEN samples in a row.
    bit [1:0]  hist [5];
    bit [15:0] xs   [5];
    bit        db   [5];
    int        age  [5];

    always @(posedge clk) begin : model
        exp_t e;
        int   len;
        bit   raw, x, nd;
        bit [15:0] mask;
        e = '0;
        for (int c = 0; c < 5; c++) begin
            len = (c == 4) ? 1 : DB_LEN;
            raw = (c == 4) ? small_btn[0] : buttons[c];
            if (reset) begin
                hist[c] = 2'b00;
                xs[c]   = 16'h0;
                db[c]   = 1'b0;
                age[c]  = 0;
            end else begin
                x       = hist[c][1];
                hist[c] = {hist[c][0], raw};
                xs[c]   = {xs[c][14:0], x};
                mask    = 16'((32'd1 << len) - 1);
                nd      = db[c];
                if ((xs[c] & mask) == (db[c] ? 16'h0 : mask)) nd = ~db[c];
                e.bp[c] = nd & ~db[c];
                e.rp[c] = ~nd & db[c];
`ifdef BUTTON_AUTOREPEAT_EN
                if (nd && !db[c]) begin
                    age[c] = 0;
                end else if (nd) begin
                    age[c]++;
                    if (age[c] >= RD && ((age[c] - RD) % RP) == 0) e.bp[c] = 1'b1;
                end
`endif
                db[c]    = nd;
                e.lvl[c] = nd;
            end
        end
        exp_q.push_back(e);
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total_cnt++;
            if (button_level === e.lvl[3:0] && button_pulse === e.bp[3:0] && release_pulse === e.rp[3:0])
                pass_cnt++;
            else
                $display("FAIL main_outputs t=%0t got lvl=%h bp=%h rp=%h expected lvl=%h bp=%h rp=%h",
                         $time, button_level, button_pulse, release_pulse, e.lvl[3:0], e.bp[3:0], e.rp[3:0]);
            total_cnt++;
            if (small_level === e.lvl[4] && small_pulse === e.bp[4] && small_release === e.rp[4])
                pass_cnt++;
            else
                $display("FAIL small_outputs t=%0t got lvl=%b bp=%b rp=%b expected lvl=%b bp=%b rp=%b",
                         $time, small_level, small_pulse, small_release, e.lvl[4], e.bp[4], e.rp[4]);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        buttons   = 4'hF;
        small_btn = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(10);
        buttons   = 4'h0;
        small_btn = 1'b0;
        cyc(10);

        // bounce on ch0: never DEBOUNCE_LEN stable samples
        buttons[0] = 1'b1; cyc(3);
        buttons[0] = 1'b0; cyc(2);
        buttons[0] = 1'b1; cyc(3);
        buttons[0] = 1'b0; cyc(10);

        // clean press/hold/release on ch2, single-cycle blip on the small instance
        buttons[2] = 1'b1;
        small_btn  = 1'b1; cyc(1);
        small_btn  = 1'b0; cyc(39);
        buttons[2] = 1'b0; cyc(10);

        // ch0 and ch3 together
        buttons = 4'b1001; cyc(10);
        buttons = 4'b0000; cyc(10);

        // reset in the middle of a debounce
        buttons[1] = 1'b1; cyc(4);
        reset = 1'b1; cyc(1);
        reset = 1'b0; cyc(12);

        // long hold on ch1 for repeat behaviour
        cyc(60);
        buttons[1] = 1'b0; cyc(10);

        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < N_CH; c++) begin
                if ($urandom_range(5) == 0) buttons[c] = ~buttons[c];
            end
            if ($urandom_range(2) == 0) small_btn = ~small_btn;
            reset = ($urandom_range(199) == 0);
            cyc(1);
        end

        reset     = 1'b0;
        buttons   = 4'h0;
        small_btn = 1'b0;
        cyc(12);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
